// File: rtl/wash_sched_pkg.sv
// Shared types and default constants for the wash queue scheduler.
package wash_sched_pkg;

    localparam int STATE_W         = 3;
    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 1024;
    localparam int RST_CYC_DEF     = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        COIN  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);

    localparam int IDW = $clog2(N);
    localparam int SW  = IDW + 1;

    logic [SW-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + SW'(k);
            if (idx >= SW'(N)) begin
                idx = idx - SW'(N);
            end
            if (!any && req[idx[IDW-1:0]]) begin
                any                        = 1'b1;
                gnt_id                     = idx[IDW-1:0];
                gnt_onehot[idx[IDW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wash_queue_scheduler.sv
// Shares one washing-machine controller between N_REQ stations: request capture,
// round-robin grant, coin/run/done sequencing, watchdog and machine fault reset.
module wash_queue_scheduler
    import wash_sched_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int RST_CYC     = RST_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_double,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         req_done,
    output logic [N_REQ-1:0]         req_fault,
    input  logic                     pause_in,
    output logic                     wm_coin_in,
    output logic                     wm_double_wash,
    output logic                     wm_timer_pause,
    output logic                     wm_reset_n,
    input  logic                     wm_wash_done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] active_id
);

    localparam int IDW  = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t           state, next_state;
    logic [N_REQ-1:0] pending, dbl, active_oh;
    logic [IDW-1:0]   rr_ptr, ptr_adv;
    logic [WD_W-1:0]  wdog;
    logic [RC_W-1:0]  rst_cnt;
    logic             wd_q;

    logic [N_REQ-1:0] gnt_onehot;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;

    logic             wash_edge, wd_hit, fault_first, release_slot;
    logic [N_REQ-1:0] accept, release_mask;

    logic             coin_nxt, dbl_wash_nxt, pause_nxt, reset_n_nxt, busy_nxt;
    logic [N_REQ-1:0] done_nxt, fault_nxt;

    assign req_ready = ~pending;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req        (pending),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .any        (gnt_any)
    );

    // Watchdog fires on the edge where the unpaused count lands on TIMEOUT_CYC-1.
    assign wash_edge    = ~wd_q & wm_wash_done;
    assign wd_hit       = ~pause_in && (wdog == WD_W'(TIMEOUT_CYC - 2));
    assign fault_first  = (state == FAULT) && (rst_cnt == '0);
    assign release_slot = (state == DONE) || fault_first;
    assign release_mask = release_slot ? active_oh : '0;
    assign accept       = req_valid & ~pending;
    assign ptr_adv      = (active_id == IDW'(N_REQ - 1)) ? '0 : active_id + IDW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gnt_any) next_state = COIN;
            COIN:    next_state = RUN;
            RUN: begin
                if (wash_edge) begin
                    next_state = DONE;
                end else if (wd_hit) begin
                    next_state = FAULT;
                end
            end
            DONE:    next_state = IDLE;
            FAULT:   if (rst_cnt == RC_W'(RST_CYC - 1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered, so this computes their values for the next state.
    always_comb begin
        coin_nxt     = (next_state == COIN);
        busy_nxt     = (next_state != IDLE);
        pause_nxt    = (next_state == RUN) && pause_in;
        reset_n_nxt  = (next_state != FAULT);
        done_nxt     = (next_state == DONE) ? active_oh : '0;
        fault_nxt    = (state == RUN && next_state == FAULT) ? active_oh : '0;
        dbl_wash_nxt = wm_double_wash;
        if (state == IDLE && gnt_any) begin
            dbl_wash_nxt = |(dbl & gnt_onehot);
        end else if (state == DONE || state == FAULT) begin
            dbl_wash_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wm_coin_in     <= 1'b0;
            wm_double_wash <= 1'b0;
            wm_timer_pause <= 1'b0;
            wm_reset_n     <= 1'b0;
            busy           <= 1'b0;
            req_done       <= '0;
            req_fault      <= '0;
        end else begin
            wm_coin_in     <= coin_nxt;
            wm_double_wash <= dbl_wash_nxt;
            wm_timer_pause <= pause_nxt;
            wm_reset_n     <= reset_n_nxt;
            busy           <= busy_nxt;
            req_done       <= done_nxt;
            req_fault      <= fault_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            dbl       <= '0;
            rr_ptr    <= '0;
            active_id <= '0;
            active_oh <= '0;
            wd_q      <= 1'b0;
        end else begin
            pending <= (pending & ~release_mask) | accept;
            dbl     <= (dbl & ~accept) | (req_double & accept);
            wd_q    <= wm_wash_done;
            if (state == IDLE && gnt_any) begin
                active_id <= gnt_id;
                active_oh <= gnt_onehot;
            end
            if (release_slot) begin
                rr_ptr <= ptr_adv;
            end
        end
    end

    // Watchdog freezes while paused and saturates; fault-reset counter runs only in FAULT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog    <= '0;
            rst_cnt <= '0;
        end else begin
            if (state == COIN) begin
                wdog <= '0;
            end else if (state == RUN && !pause_in && wdog != WD_W'(TIMEOUT_CYC - 1)) begin
                wdog <= wdog + WD_W'(1);
            end
            if (state == FAULT) begin
                rst_cnt <= rst_cnt + RC_W'(1);
            end else begin
                rst_cnt <= '0;
            end
        end
    end

endmodule
